// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: latches decode operands and control bundles for EX,
// detects load-use hazards, inserts bubbles on hazard/flush and counts them.
module id_ex_pipe_reg #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [4:0]        id_ex,
  input  logic [2:0]        id_m,
  input  logic [2:0]        id_wb,
  output logic              ex_valid,
  output logic [PC_W-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_ctrl_ex,
  output logic [2:0]        ex_ctrl_m,
  output logic [2:0]        ex_ctrl_wb,
  output logic              load_use_stall,
  output logic              if_id_hold,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_rd;
  logic [4:0]        r_ctrl_ex;
  logic [2:0]        r_ctrl_m;
  logic [2:0]        r_ctrl_wb;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_ex_is_load;
  logic              w_rs1_match;
  logic              w_rs2_match;
  logic              w_load_use;
  logic              w_bubble;
  logic              w_cnt_sat;

  // A load in EX is reg_write with mem_to_reg selecting memory data (2'b11).
  assign w_ex_is_load = r_valid & r_ctrl_wb[2] & (r_ctrl_wb[1:0] == 2'b11) & (r_rd != 5'd0);
  assign w_rs1_match  = id_uses_rs1 & (id_rs1 == r_rd);
  assign w_rs2_match  = id_uses_rs2 & (id_rs2 == r_rd);
  assign w_load_use   = w_ex_is_load & id_valid & (w_rs1_match | w_rs2_match);

  // stall_i freezes everything, so a bubble only lands when the register advances.
  assign w_bubble  = ~stall_i & (flush_i | w_load_use);
  assign w_cnt_sat = &r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl_ex  <= '0;
      r_ctrl_m   <= '0;
      r_ctrl_wb  <= '0;
    end else if (!stall_i) begin
      if (w_bubble) begin
        r_valid    <= 1'b0;
        r_pc       <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_rs1      <= '0;
        r_rs2      <= '0;
        r_rd       <= '0;
        r_ctrl_ex  <= '0;
        r_ctrl_m   <= '0;
        r_ctrl_wb  <= '0;
      end else begin
        r_valid    <= id_valid;
        r_pc       <= id_pc;
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
        r_imm      <= id_imm;
        r_rs1      <= id_rs1;
        r_rs2      <= id_rs2;
        r_rd       <= id_rd;
        // An empty ID slot must never carry side-effecting control into EX.
        r_ctrl_ex  <= id_valid ? id_ex : 5'd0;
        r_ctrl_m   <= id_valid ? id_m  : 3'd0;
        r_ctrl_wb  <= id_valid ? id_wb : 3'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && !w_cnt_sat) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign ex_valid       = r_valid;
  assign ex_pc          = r_pc;
  assign ex_rs1_data    = r_rs1_data;
  assign ex_rs2_data    = r_rs2_data;
  assign ex_imm         = r_imm;
  assign ex_rs1         = r_rs1;
  assign ex_rs2         = r_rs2;
  assign ex_rd          = r_rd;
  assign ex_ctrl_ex     = r_ctrl_ex;
  assign ex_ctrl_m      = r_ctrl_m;
  assign ex_ctrl_wb     = r_ctrl_wb;
  assign load_use_stall = w_load_use;
  assign if_id_hold     = stall_i | w_load_use;
  assign bubble_cnt     = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: a driver pushes model predictions per cycle,
// a monitor pops and compares; a second instance with a 4-bit counter checks saturation.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        rst, stall, flush, valid;
    logic [63:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2;
    logic        u1, u2;
    logic [4:0]  rd, cex;
    logic [2:0]  cm, cwb;
  } stim_t;

  typedef struct packed {
    logic        v;
    logic [63:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd, cex;
    logic [2:0]  cm, cwb;
  } slot_t;

  typedef struct packed {
    logic        lus, hold;
    slot_t       st;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall_i, flush_i, id_valid, id_uses_rs1, id_uses_rs2;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_ex;
  logic [2:0]  id_m, id_wb;

  logic        ex_valid, load_use_stall, if_id_hold;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_ctrl_ex;
  logic [2:0]  ex_ctrl_m, ex_ctrl_wb;
  logic [31:0] bubble_cnt;

  logic        s_valid, s_lus, s_hold;
  logic [63:0] s_pc, s_a, s_b, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd, s_cex;
  logic [2:0]  s_cm, s_cwb;
  logic [3:0]  s_cnt;

  id_ex_pipe_reg #(.XLEN(64), .PC_W(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl_ex(ex_ctrl_ex), .ex_ctrl_m(ex_ctrl_m), .ex_ctrl_wb(ex_ctrl_wb),
    .load_use_stall(load_use_stall), .if_id_hold(if_id_hold), .bubble_cnt(bubble_cnt)
  );

  id_ex_pipe_reg #(.XLEN(64), .PC_W(64), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_ex(id_ex), .id_m(id_m), .id_wb(id_wb),
    .ex_valid(s_valid), .ex_pc(s_pc), .ex_rs1_data(s_a), .ex_rs2_data(s_b),
    .ex_imm(s_imm), .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd),
    .ex_ctrl_ex(s_cex), .ex_ctrl_m(s_cm), .ex_ctrl_wb(s_cwb),
    .load_use_stall(s_lus), .if_id_hold(s_hold), .bubble_cnt(s_cnt)
  );

  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  sb_q[$];
  event  ev_issue;

  slot_t       m_slot;
  logic [31:0] m_cnt;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Model: EX holds one instruction record; a load is reg_write+mem_to_reg=11 with rd!=0.
  function automatic logic hazard(stim_t s, slot_t e);
    logic is_load;
    is_load = e.v && e.cwb == 3'b111 && e.rd != 0;
    return is_load && s.valid && ((s.u1 && s.rs1 == e.rd) || (s.u2 && s.rs2 == e.rd));
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic hz;
    @(negedge clk);
    rst = s.rst; stall_i = s.stall; flush_i = s.flush; id_valid = s.valid;
    id_pc = s.pc; id_rs1_data = s.a; id_rs2_data = s.b; id_imm = s.imm;
    id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
    id_rd = s.rd; id_ex = s.cex; id_m = s.cm; id_wb = s.cwb;
    if (s.rst) begin
      m_slot = '0;
      m_cnt  = 0;
    end
    hz = hazard(s, m_slot);
    e.lus  = hz;
    e.hold = s.stall | hz;
    if (!s.rst && !s.stall) begin
      if (s.flush || hz) begin
        m_slot = '0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_slot.v   = s.valid;
        m_slot.pc  = s.pc;   m_slot.a   = s.a;   m_slot.b  = s.b;  m_slot.imm = s.imm;
        m_slot.rs1 = s.rs1;  m_slot.rs2 = s.rs2; m_slot.rd = s.rd;
        m_slot.cex = s.valid ? s.cex : 5'd0;
        m_slot.cm  = s.valid ? s.cm  : 3'd0;
        m_slot.cwb = s.valid ? s.cwb : 3'd0;
      end
    end
    e.st  = m_slot;
    e.cnt = m_cnt;
    sb_q.push_back(e);
    #1 -> ev_issue;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(ev_issue);
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q[0];
        chk("load_use_stall", load_use_stall, e.lus);
        chk("if_id_hold", if_id_hold, e.hold);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("ex_valid", ex_valid, e.st.v);
        chk("ex_pc", ex_pc, e.st.pc);
        chk("ex_rs1_data", ex_rs1_data, e.st.a);
        chk("ex_rs2_data", ex_rs2_data, e.st.b);
        chk("ex_imm", ex_imm, e.st.imm);
        chk("ex_rs1", ex_rs1, e.st.rs1);
        chk("ex_rs2", ex_rs2, e.st.rs2);
        chk("ex_rd", ex_rd, e.st.rd);
        chk("ex_ctrl_ex", ex_ctrl_ex, e.st.cex);
        chk("ex_ctrl_m", ex_ctrl_m, e.st.cm);
        chk("ex_ctrl_wb", ex_ctrl_wb, e.st.cwb);
        chk("bubble_cnt", bubble_cnt, e.cnt);
        chk("bubble_cnt_sat4", s_cnt, (e.cnt > 15) ? 64'd15 : 64'(e.cnt));
      end
    end
  end

  function automatic stim_t rnd();
    stim_t s;
    s.rst   = ($urandom_range(0, 199) == 0);
    s.stall = ($urandom_range(0, 99) < 15);
    s.flush = ($urandom_range(0, 99) < 12);
    s.valid = ($urandom_range(0, 99) < 85);
    s.pc    = {$urandom, $urandom};
    s.a     = {$urandom, $urandom};
    s.b     = {$urandom, $urandom};
    s.imm   = {$urandom, $urandom};
    s.rs1   = 5'($urandom_range(0, 7));
    s.rs2   = 5'($urandom_range(0, 7));
    s.u1    = 1'($urandom);
    s.u2    = 1'($urandom);
    s.rd    = 5'($urandom_range(0, 7));
    s.cex   = 5'($urandom);
    s.cm    = 3'($urandom);
    s.cwb   = ($urandom_range(0, 99) < 40) ? 3'b111 : 3'($urandom);
    return s;
  endfunction

  function automatic stim_t ins(logic [63:0] pc, logic [4:0] rd, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [2:0] m, logic [2:0] wb);
    stim_t s;
    s = '0;
    s.valid = 1'b1; s.pc = pc; s.rd = rd; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
    s.cm = m; s.cwb = wb; s.cex = 5'h0A;
    s.a = 64'h1111_0000 + pc; s.b = 64'h2222_0000 + pc; s.imm = pc ^ 64'hFF;
    return s;
  endfunction

  initial begin : driver
    stim_t s;
    m_slot = '0;
    m_cnt  = 0;
    rst = 1'b1; stall_i = 0; flush_i = 0; id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_ex = 0; id_m = 0; id_wb = 0;

    // reset with random inputs, then first instruction at 0x80
    repeat (2) begin s = rnd(); s.rst = 1'b1; step(s); end
    step(ins(64'h80, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 3'b100));
    // lw x5 followed by dependent add x6,x5,x1: bubble then retry
    step(ins(64'h84, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 3'b000, 3'b111));
    step(ins(64'h88, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 3'b000, 3'b100));
    step(ins(64'h88, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 3'b000, 3'b100));
    // lw x0 never hazards; unused rs2 match never hazards
    step(ins(64'h8C, 5'd0, 5'd2, 1'b1, 5'd0, 1'b0, 3'b000, 3'b111));
    step(ins(64'h90, 5'd7, 5'd0, 1'b1, 5'd0, 1'b1, 3'b000, 3'b100));
    step(ins(64'h94, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 3'b000, 3'b111));
    step(ins(64'h98, 5'd7, 5'd3, 1'b1, 5'd5, 1'b0, 3'b000, 3'b100));
    // flush of a valid beq; then flush coinciding with a hazard
    s = ins(64'h9C, 5'd0, 5'd1, 1'b1, 5'd2, 1'b1, 3'b110, 3'b000); s.flush = 1'b1; step(s);
    step(ins(64'hA0, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 3'b000, 3'b111));
    s = ins(64'hA4, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0, 3'b000, 3'b100); s.flush = 1'b1; step(s);
    // stall for 3 cycles with changing inputs and pending flush, then release
    step(ins(64'hA8, 5'd9, 5'd1, 1'b1, 5'd2, 1'b1, 3'b000, 3'b100));
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b1; step(s);
    end
    s = rnd(); s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b1; step(s);
    // 20 consecutive flushes: the 4-bit counter must stop at 15
    for (int i = 0; i < 20; i++) begin
      s = rnd(); s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b1; step(s);
    end
    for (int i = 0; i < 2000; i++) step(rnd());

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
